// File: rtl/pcie_cq_pkg.sv
// Shared definitions for the PCIe completer-request (CQ) path: request types,
// descriptor field positions, completion status codes and byte-enable helpers.
package pcie_cq_pkg;

    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;
    localparam logic [3:0] REQ_IO_RD  = 4'b0010;
    localparam logic [3:0] REQ_IO_WR  = 4'b0011;

    localparam int DESC_ADDR_LSB  = 2;
    localparam int DESC_ADDR_MSB  = 63;
    localparam int DESC_DW_LSB    = 64;
    localparam int DESC_TYPE_LSB  = 75;
    localparam int DESC_RID_LSB   = 80;
    localparam int DESC_TAG_LSB   = 96;
    localparam int DESC_BAR_LSB   = 112;
    localparam int DESC_TC_LSB    = 121;
    localparam int DESC_ATTR_LSB  = 124;

    localparam int TUSER_FBE_LSB  = 0;
    localparam int TUSER_LBE_LSB  = 4;
    localparam int TUSER_SOP      = 40;

    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } cq_state_e;

    // Messages (1100..1111) and memory writes need no completion.
    function automatic logic is_posted_type(input logic [3:0] req_type);
        return (req_type == REQ_MEM_WR) || (req_type[3:2] == 2'b11);
    endfunction

    function automatic logic [1:0] first_be_to_offset(input logic [3:0] first_be);
        logic [1:0] off;
        casez (first_be)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: off = 2'd0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/cq_parser.sv
// Single-beat completer-request parser: decodes the CQ descriptor, holds one
// request for user logic and discards multi-beat or unsupported posted TLPs.
//
// state | meaning
// IDLE  | ready for a new TLP (tready = 1)
// HOLD  | request presented on req_*, waiting for req_ready (tready = 0)
// DRAIN | swallowing the remaining beats of a dropped multi-beat TLP
module cq_parser
    import pcie_cq_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int MAX_DW     = 4
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    input  logic [DATA_WIDTH-1:0]    m_axis_cq_tdata,
    input  logic [84:0]              m_axis_cq_tuser,
    input  logic [DATA_WIDTH/32-1:0] m_axis_cq_tkeep,
    input  logic                     m_axis_cq_tlast,
    input  logic                     m_axis_cq_tvalid,
    output logic [21:0]              m_axis_cq_tready,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic                     req_is_write,
    output logic                     req_unsupported,
    output logic [63:0]              req_addr,
    output logic [2:0]               req_bar_id,
    output logic [10:0]              req_dword_count,
    output logic [15:0]              req_requester_id,
    output logic [7:0]               req_tag,
    output logic [2:0]               req_tc,
    output logic [2:0]               req_attr,
    output logic [3:0]               req_first_be,
    output logic [3:0]               req_last_be,
    output logic [6:0]               req_lower_addr,
    output logic [127:0]             req_wdata,
    output logic [15:0]              drop_count
);

    cq_state_e r_state;
    cq_state_e w_state_nxt;
    logic      w_capture;
    logic      w_drop;

    logic         r_is_write;
    logic         r_unsupported;
    logic [63:0]  r_addr;
    logic [2:0]   r_bar_id;
    logic [10:0]  r_dword_count;
    logic [15:0]  r_requester_id;
    logic [7:0]   r_tag;
    logic [2:0]   r_tc;
    logic [2:0]   r_attr;
    logic [3:0]   r_first_be;
    logic [3:0]   r_last_be;
    logic [6:0]   r_lower_addr;
    logic [127:0] r_wdata;
    logic [15:0]  r_drop_count;

    logic         w_tready;
    logic         w_beat;
    logic         w_sop;
    logic [3:0]   w_type;
    logic [10:0]  w_dw;
    logic [63:0]  w_addr;
    logic [3:0]   w_first_be;
    logic         w_len_ok;
    logic         w_wr_ok;
    logic         w_rd_ok;
    logic         w_unused;

    assign w_tready   = (r_state != ST_HOLD);
    assign w_beat     = m_axis_cq_tvalid && w_tready;
    assign w_sop      = m_axis_cq_tuser[TUSER_SOP];
    assign w_type     = m_axis_cq_tdata[DESC_TYPE_LSB +: 4];
    assign w_dw       = m_axis_cq_tdata[DESC_DW_LSB +: 11];
    assign w_addr     = {m_axis_cq_tdata[DESC_ADDR_MSB:DESC_ADDR_LSB], 2'b00};
    assign w_first_be = m_axis_cq_tuser[TUSER_FBE_LSB +: 4];
    assign w_len_ok   = (w_dw >= 11'd1) && (w_dw <= 11'(MAX_DW));
    assign w_wr_ok    = (w_type == REQ_MEM_WR) && w_len_ok;
    assign w_rd_ok    = (w_type == REQ_MEM_RD) && w_len_ok;

    assign w_unused = ^{m_axis_cq_tdata[1:0], m_axis_cq_tdata[79], m_axis_cq_tdata[111:104],
                        m_axis_cq_tdata[120:115], m_axis_cq_tdata[127],
                        m_axis_cq_tuser[84:41], m_axis_cq_tuser[39:8], m_axis_cq_tkeep};

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_beat && w_sop) begin
                    if (!m_axis_cq_tlast) begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else if (is_posted_type(w_type) && !w_wr_ok) begin
                        w_drop = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (req_ready) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (w_beat && m_axis_cq_tlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_is_write     <= 1'b0;
            r_unsupported  <= 1'b0;
            r_addr         <= '0;
            r_bar_id       <= '0;
            r_dword_count  <= '0;
            r_requester_id <= '0;
            r_tag          <= '0;
            r_tc           <= '0;
            r_attr         <= '0;
            r_first_be     <= '0;
            r_last_be      <= '0;
            r_lower_addr   <= '0;
            r_wdata        <= '0;
        end else if (w_capture) begin
            r_is_write     <= w_wr_ok;
            r_unsupported  <= !(w_wr_ok || w_rd_ok);
            r_addr         <= w_addr;
            r_bar_id       <= m_axis_cq_tdata[DESC_BAR_LSB +: 3];
            r_dword_count  <= w_dw;
            r_requester_id <= m_axis_cq_tdata[DESC_RID_LSB +: 16];
            r_tag          <= m_axis_cq_tdata[DESC_TAG_LSB +: 8];
            r_tc           <= m_axis_cq_tdata[DESC_TC_LSB +: 3];
            r_attr         <= m_axis_cq_tdata[DESC_ATTR_LSB +: 3];
            r_first_be     <= w_first_be;
            r_last_be      <= m_axis_cq_tuser[TUSER_LBE_LSB +: 4];
            r_lower_addr   <= {w_addr[6:2], first_be_to_offset(w_first_be)};
            r_wdata        <= w_wr_ok ? m_axis_cq_tdata[255:128] : 128'd0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset)                             r_drop_count <= '0;
        else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end

    // The descriptor occupies the first four DWords of every SOP beat.
    always_ff @(posedge user_clk) begin
        if (!user_reset && w_beat && w_sop)
            assert (m_axis_cq_tkeep[3:0] == 4'hF);
    end

    assign m_axis_cq_tready = {22{w_tready}};
    assign req_valid        = (r_state == ST_HOLD);
    assign req_is_write     = r_is_write;
    assign req_unsupported  = r_unsupported;
    assign req_addr         = r_addr;
    assign req_bar_id       = r_bar_id;
    assign req_dword_count  = r_dword_count;
    assign req_requester_id = r_requester_id;
    assign req_tag          = r_tag;
    assign req_tc           = r_tc;
    assign req_attr         = r_attr;
    assign req_first_be     = r_first_be;
    assign req_last_be      = r_last_be;
    assign req_lower_addr   = r_lower_addr;
    assign req_wdata        = r_wdata;
    assign drop_count       = r_drop_count;

endmodule

// File: tb/tb_cq_parser.sv
// Scoreboard bench for cq_parser: a request-level model predicts which TLPs
// reach the user side and how many are dropped; a monitor checks each handshake.
module tb_cq_parser;

    logic         user_clk;
    logic         user_reset;
    logic [255:0] m_axis_cq_tdata;
    logic [84:0]  m_axis_cq_tuser;
    logic [7:0]   m_axis_cq_tkeep;
    logic         m_axis_cq_tlast;
    logic         m_axis_cq_tvalid;
    logic [21:0]  m_axis_cq_tready;
    logic         req_valid;
    logic         req_ready;
    logic         req_is_write;
    logic         req_unsupported;
    logic [63:0]  req_addr;
    logic [2:0]   req_bar_id;
    logic [10:0]  req_dword_count;
    logic [15:0]  req_requester_id;
    logic [7:0]   req_tag;
    logic [2:0]   req_tc;
    logic [2:0]   req_attr;
    logic [3:0]   req_first_be;
    logic [3:0]   req_last_be;
    logic [6:0]   req_lower_addr;
    logic [127:0] req_wdata;
    logic [15:0]  drop_count;

    cq_parser #(.DATA_WIDTH(256), .MAX_DW(4)) dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .m_axis_cq_tdata(m_axis_cq_tdata), .m_axis_cq_tuser(m_axis_cq_tuser),
        .m_axis_cq_tkeep(m_axis_cq_tkeep), .m_axis_cq_tlast(m_axis_cq_tlast),
        .m_axis_cq_tvalid(m_axis_cq_tvalid), .m_axis_cq_tready(m_axis_cq_tready),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_write(req_is_write), .req_unsupported(req_unsupported),
        .req_addr(req_addr), .req_bar_id(req_bar_id),
        .req_dword_count(req_dword_count), .req_requester_id(req_requester_id),
        .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
        .req_first_be(req_first_be), .req_last_be(req_last_be),
        .req_lower_addr(req_lower_addr), .req_wdata(req_wdata),
        .drop_count(drop_count)
    );

    typedef struct packed {
        logic         is_write;
        logic         unsup;
        logic [63:0]  addr;
        logic [2:0]   bar;
        logic [10:0]  dw;
        logic [15:0]  rid;
        logic [7:0]   tag;
        logic [2:0]   tc;
        logic [2:0]   attr;
        logic [3:0]   fbe;
        logic [3:0]   lbe;
        logic [6:0]   lower;
        logic [127:0] wdata;
    } req_t;

    typedef struct {
        logic [3:0]   typ;
        logic [10:0]  dw;
        logic [63:0]  addr;
        logic [2:0]   bar;
        logic [15:0]  rid;
        logic [7:0]   tag;
        logic [2:0]   tc;
        logic [2:0]   attr;
        logic [3:0]   fbe;
        logic [3:0]   lbe;
        logic [127:0] payload;
        int           nbeats;
        bit           sop;
    } tlp_t;

    int      checks = 0;
    int      failures = 0;
    longint  cyc = 0;
    int      mode = 2;          // 0 random ready, 1 ready high, 2 ready low
    req_t    exp_q[$];
    longint  acc_cyc[$];
    int      model_drops = 0;

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;
    always @(posedge user_clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic req_t dut_req();
        req_t r;
        r.is_write = req_is_write;   r.unsup = req_unsupported;
        r.addr     = req_addr;       r.bar   = req_bar_id;
        r.dw       = req_dword_count; r.rid  = req_requester_id;
        r.tag      = req_tag;        r.tc    = req_tc;
        r.attr     = req_attr;       r.fbe   = req_first_be;
        r.lbe      = req_last_be;    r.lower = req_lower_addr;
        r.wdata    = req_wdata;
        return r;
    endfunction

    // Reference model: what the user side should see for one TLP.
    task automatic predict(input tlp_t t, output bit present, output bit dropped, output req_t r);
        bit      len_ok;
        int      off;
        present = 0;
        dropped = 0;
        r = '0;
        len_ok = (t.dw >= 1) && (t.dw <= 4);
        if (!t.sop) return;
        if (t.nbeats > 1)           dropped = 1;
        else if (t.typ == 4'b0001)  begin if (len_ok) present = 1; else dropped = 1; end
        else if (t.typ >= 4'b1100)  dropped = 1;
        else                        present = 1;
        off = 0;
        for (int i = 3; i >= 0; i--) if (t.fbe[i]) off = i;
        r.is_write = present && (t.typ == 4'b0001);
        r.unsup    = present && !(((t.typ == 4'b0000) || (t.typ == 4'b0001)) && len_ok);
        r.addr     = {t.addr[63:2], 2'b00};
        r.bar      = t.bar;   r.dw  = t.dw;  r.rid  = t.rid; r.tag = t.tag;
        r.tc       = t.tc;    r.attr = t.attr; r.fbe = t.fbe; r.lbe = t.lbe;
        r.lower    = {t.addr[6:2], 2'(off)};
        r.wdata    = r.is_write ? t.payload : 128'd0;
    endtask

    task automatic send_tlp(input tlp_t t);
        logic [127:0] d;
        bit           present, dropped;
        req_t         r;
        int           budget;
        predict(t, present, dropped, r);
        if (present) exp_q.push_back(r);
        if (dropped && model_drops < 65535) model_drops++;
        d = '0;
        d[63:0]    = {t.addr[63:2], 2'($urandom_range(0, 3))};
        d[74:64]   = t.dw;
        d[78:75]   = t.typ;
        d[95:80]   = t.rid;
        d[103:96]  = t.tag;
        d[111:104] = 8'($urandom);
        d[114:112] = t.bar;
        d[120:115] = 6'($urandom);
        d[123:121] = t.tc;
        d[126:124] = t.attr;
        for (int b = 0; b < t.nbeats; b++) begin
            @(negedge user_clk);
            m_axis_cq_tvalid = 1'b1;
            m_axis_cq_tlast  = (b == t.nbeats - 1);
            m_axis_cq_tuser  = {44'd0, (b == 0) && t.sop, 32'd0, t.lbe, t.fbe};
            if (b == 0) m_axis_cq_tdata = {t.payload, d};
            else        m_axis_cq_tdata = {$urandom, $urandom, $urandom, $urandom,
                                           $urandom, $urandom, $urandom, $urandom};
            budget = 0;
            while (!m_axis_cq_tready[0]) begin
                @(negedge user_clk);
                budget++;
                if (budget > 1000) begin
                    $display("FAIL tready_timeout actual=0 required=1");
                    failures++;
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $fatal(1, "tready never returned");
                end
            end
            @(posedge user_clk);
            #1;
            m_axis_cq_tvalid = 1'b0;
        end
    endtask

    function automatic tlp_t base_read(input logic [7:0] tag);
        tlp_t t;
        t.typ = 4'b0000; t.dw = 11'd1; t.addr = 64'h0000_0000_0000_2000;
        t.bar = 3'd1; t.rid = 16'h0100; t.tag = tag; t.tc = 3'd0; t.attr = 3'd0;
        t.fbe = 4'b1111; t.lbe = 4'b0000; t.payload = '0; t.nbeats = 1; t.sop = 1;
        return t;
    endfunction

    function automatic tlp_t rand_tlp();
        tlp_t t;
        logic [3:0] types [7];
        types = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0011, 4'b1100};
        t.typ = types[$urandom_range(0, 6)];
        if ($urandom_range(0, 19) == 0) t.typ = 4'b1101;
        if ($urandom_range(0, 9) < 8) t.dw = 11'($urandom_range(1, 4));
        else if ($urandom_range(0, 1) == 0) t.dw = 11'd0;
        else t.dw = 11'($urandom_range(5, 12));
        t.addr = {$urandom, $urandom};
        t.bar = 3'($urandom); t.rid = 16'($urandom); t.tag = 8'($urandom);
        t.tc = 3'($urandom); t.attr = 3'($urandom);
        t.fbe = 4'($urandom); t.lbe = 4'($urandom);
        t.payload = {$urandom, $urandom, $urandom, $urandom};
        t.nbeats = 1;
        if (t.typ == 4'b0001 && $urandom_range(0, 4) == 0) t.nbeats = $urandom_range(2, 3);
        else if ($urandom_range(0, 19) == 0) t.nbeats = 2;
        t.sop = 1;
        if ($urandom_range(0, 24) == 0) begin t.sop = 0; t.nbeats = 1; end
        return t;
    endfunction

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(negedge user_clk);
            budget++;
        end
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic chk_drops();
        @(negedge user_clk);
        chk("drop_count", 128'(drop_count), 128'(model_drops));
    endtask

    // Monitor: drives req_ready and checks every accepted request in order.
    initial begin : monitor
        bit   prev_hold;
        req_t prev_r;
        req_t cur;
        req_t exp;
        prev_hold = 0;
        prev_r = '0;
        req_ready = 1'b0;
        forever begin
            @(negedge user_clk);
            case (mode)
                0:       req_ready = ($urandom_range(0, 2) != 0);
                1:       req_ready = 1'b1;
                default: req_ready = 1'b0;
            endcase
            cur = dut_req();
            if (req_valid && prev_hold) begin
                checks++;
                if (cur !== prev_r) begin
                    failures++;
                    $display("FAIL hold_stable actual=%0h required=%0h", cur, prev_r);
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req actual=%0h required=none", cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        failures++;
                        $display("FAIL req_fields actual=%0h required=%0h", cur, exp);
                    end
                end
            end
            prev_hold = req_valid && !req_ready;
            prev_r    = cur;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        tlp_t t;
        int   base;
        user_reset       = 1'b1;
        m_axis_cq_tvalid = 1'b0;
        m_axis_cq_tlast  = 1'b0;
        m_axis_cq_tdata  = '0;
        m_axis_cq_tuser  = '0;
        m_axis_cq_tkeep  = 8'hFF;
        mode = 2;
        repeat (3) @(negedge user_clk);
        user_reset = 1'b0;
        @(negedge user_clk);
        chk("rst_valid", 128'(req_valid), 128'd0);
        chk("rst_tready", 128'(m_axis_cq_tready), 128'h3FFFFF);
        chk("rst_drop", 128'(drop_count), 128'd0);
        chk("rst_addr", 128'(req_addr), 128'd0);

        // Memory read with lower address derived from first_be
        t = base_read(8'h2A);
        t.addr = 64'h0000_0000_0000_1004; t.fbe = 4'b1100;
        send_tlp(t);
        @(negedge user_clk);
        chk("rd_valid", 128'(req_valid), 128'd1);
        chk("rd_tready_low", 128'(m_axis_cq_tready), 128'd0);
        chk("rd_lower_addr", 128'(req_lower_addr), 128'h06);
        chk("rd_tag", 128'(req_tag), 128'h2A);
        chk("rd_unsup", 128'(req_unsupported), 128'd0);
        chk("rd_is_write", 128'(req_is_write), 128'd0);
        repeat (3) @(negedge user_clk);
        chk("rd_still_valid", 128'(req_valid), 128'd1);
        chk("rd_still_blocked", 128'(m_axis_cq_tready), 128'd0);
        mode = 1;
        wait_drain();

        // Two-DW write
        mode = 2;
        t = base_read(8'h31);
        t.typ = 4'b0001; t.dw = 11'd2; t.payload = 128'hDEADBEEF_CAFEF00D;
        send_tlp(t);
        @(negedge user_clk);
        chk("wr_is_write", 128'(req_is_write), 128'd1);
        chk("wr_wdata", 128'(req_wdata[63:0]), 128'hDEADBEEF_CAFEF00D);
        chk("wr_dw", 128'(req_dword_count), 128'd2);
        mode = 1;
        wait_drain();

        // Two-beat 8-DW write is dropped, then a normal read follows
        t = base_read(8'h40);
        t.typ = 4'b0001; t.dw = 11'd8; t.nbeats = 2;
        send_tlp(t);
        @(negedge user_clk);
        chk("drop_no_valid", 128'(req_valid), 128'd0);
        chk("drop_count_one", 128'(drop_count), 128'd1);
        chk("drop_back_idle", 128'(m_axis_cq_tready), 128'h3FFFFF);
        send_tlp(base_read(8'h41));
        wait_drain();

        // IO read and oversize read flagged unsupported
        mode = 2;
        t = base_read(8'h50);
        t.typ = 4'b0010;
        send_tlp(t);
        @(negedge user_clk);
        chk("io_unsup", 128'(req_unsupported), 128'd1);
        chk("io_is_write", 128'(req_is_write), 128'd0);
        mode = 1;
        wait_drain();
        mode = 2;
        t = base_read(8'h51);
        t.dw = 11'd5;
        send_tlp(t);
        @(negedge user_clk);
        chk("rd5_unsup", 128'(req_unsupported), 128'd1);
        mode = 1;
        wait_drain();

        // Back-to-back reads with ready held high: one request every 2 cycles
        base = acc_cyc.size();
        for (int i = 0; i < 6; i++) send_tlp(base_read(8'(8'h10 + i)));
        wait_drain();
        for (int i = 1; i < 6; i++)
            chk("b2b_spacing", 128'(acc_cyc[base + i] - acc_cyc[base + i - 1]), 128'd2);

        // Reset while a request is held
        mode = 2;
        send_tlp(base_read(8'h66));
        @(negedge user_clk);
        chk("hold_before_rst", 128'(req_valid), 128'd1);
        user_reset = 1'b1;
        @(negedge user_clk);
        chk("rst_hold_valid", 128'(req_valid), 128'd0);
        chk("rst_hold_tready", 128'(m_axis_cq_tready), 128'h3FFFFF);
        chk("rst_hold_drop", 128'(drop_count), 128'd0);
        chk("rst_hold_tag", 128'(req_tag), 128'd0);
        exp_q.delete();
        model_drops = 0;
        user_reset = 1'b0;
        mode = 1;
        send_tlp(base_read(8'h77));
        wait_drain();

        // Randomized traffic with random user backpressure
        mode = 0;
        for (int n = 0; n < 300; n++) begin
            send_tlp(rand_tlp());
            chk_drops();
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cq_parser.md
Name: cq_parser

Overview:
- Receives completer requests (host -> FPGA) from the PCIe IP core's m_axis_cq_* stream (256-bit, DWord-aligned).
- Decodes the 128-bit CQ descriptor and captures up to 4 DWords of write payload.
- Presents one request at a time to user logic on a valid/ready interface. Its outputs feed the completion formatter's requester ID, tag, TC, lower address and DWord count inputs.
- Discards multi-beat writes and counts them.

Parameters:
- DATA_WIDTH, 256, CQ stream width; only 256 supported.
- MAX_DW, 4, largest read/write payload in DWords the user side handles.

Ports:
- user_clk  in  1  PCIe user clock; single clock domain.
- user_reset  in  1  synchronous, active-high reset.
- m_axis_cq_tdata  in  DATA_WIDTH  descriptor [127:0], payload [255:128].
- m_axis_cq_tuser  in  85  [3:0] first_be, [7:4] last_be, [40] sop; other bits ignored.
- m_axis_cq_tkeep  in  DATA_WIDTH/32  ignored except by assertions.
- m_axis_cq_tlast  in  1  last beat of TLP.
- m_axis_cq_tvalid  in  1  beat valid.
- m_axis_cq_tready  out  22  all bits driven identically.
- req_valid  out  1  request held for user.
- req_ready  in  1  user accepts request.
- req_is_write  out  1  1 = memory write (type 0001); 0 = memory read (type 0000).
- req_unsupported  out  1  non-posted request user must complete with status 3'b001.
- req_addr  out  64  {descriptor[63:2], 2'b00}.
- req_bar_id  out  3  descriptor[114:112].
- req_dword_count  out  11  descriptor[74:64].
- req_requester_id  out  16  descriptor[95:80].
- req_tag  out  8  descriptor[103:96].
- req_tc  out  3  descriptor[123:121].
- req_attr  out  3  descriptor[126:124].
- req_first_be  out  4  tuser[3:0].
- req_last_be  out  4  tuser[7:4].
- req_lower_addr  out  7  {addr[6:2], byte offset of lowest set first_be bit; 2'b00 if first_be = 0}.
- req_wdata  out  128  tdata[255:128]; zero for reads.
- drop_count  out  16  saturating count of discarded TLPs.

Behaviour:
- Beat handshake: a beat is accepted when m_axis_cq_tvalid && m_axis_cq_tready[0]. A request is accepted when req_valid && req_ready.
- States:
  - IDLE: tready = 1.
  - HOLD: tready = 0, req_valid = 1.
  - DRAIN: tready = 1, outputs nothing.
- IDLE, SOP beat accepted with tlast = 1:
  - Register all req_* fields.
  - Go to HOLD.
  - req_valid rises the next cycle (1-cycle latency).
- Classification on capture:
  - Read, dword_count 1..MAX_DW: req_unsupported = 0.
  - Write, dword_count 1..MAX_DW: req_is_write = 1, req_unsupported = 0.
  - Any other non-posted type (IO, atomic, read of 0 or >MAX_DW DW): req_unsupported = 1, req_is_write = 0.
  - Other posted types (e.g. message) with tlast = 1: dropped, drop_count++, stay in IDLE.
- IDLE, SOP beat accepted with tlast = 0: payload exceeds one beat. Drop it, drop_count++, go to DRAIN.
- DRAIN: consume beats; the beat with tlast = 1 returns the block to IDLE.
- HOLD:
  - All req_* fields stable while req_valid = 1.
  - On request accept: req_valid = 0 next cycle, go to IDLE.
  - Exactly one bubble cycle before the next beat can be accepted; peak rate is 1 request per 2 cycles.
- Non-SOP beat accepted in IDLE (protocol error): ignored, not counted.
- drop_count saturates at 16'hFFFF; it does not wrap.
- Reset (any state, including mid-HOLD or mid-DRAIN), effective the next cycle:
  - state = IDLE.
  - req_valid = 0.
  - tready = 1 (first cycle after reset release).
  - All req_* fields = 0.
  - drop_count = 0.
  - A held request is discarded without a handshake.
- No combinational path from m_axis_cq_tvalid or req_ready to any output; tready is decoded from registered state only.

Decomposition:
- Shared package pcie_cq_pkg:
  - Request-type constants: REQ_MEM_RD = 4'b0000, REQ_MEM_WR = 4'b0001, REQ_IO_RD, REQ_IO_WR.
  - Descriptor field offset localparams.
  - Completion status codes: SC, UR, CRS, CA.
  - Function first_be_to_offset(4-bit) -> 2-bit.
- No sub-module; a single FSM plus capture registers.

Test Plan:
- Mem read: addr 0x0000_1004, first_be 4'b1100, dw = 1, tag 0x2A, tlast = 1 -> 1 cycle later: req_valid = 1, is_write = 0, lower_addr = 7'h06, tag = 0x2A, unsupported = 0; tready = 0 until req_ready.
- Mem write: dw = 2, payload 0xDEADBEEF_CAFEF00D -> req_is_write = 1, req_wdata[63:0] = 0xDEADBEEF_CAFEF00D, dword_count = 2.
- Write of 8 DW (2 beats) -> no req_valid; drop_count = 1; second beat consumed; back in IDLE; next read request presented normally.
- IO read (type 0010) -> req_valid with req_unsupported = 1; a read with dw = 5 -> req_unsupported = 1.
- Back-to-back reads with req_ready held high -> req_valid pulses on alternate cycles; no request lost or duplicated; tags preserved in order.
- user_reset asserted during HOLD -> next cycle req_valid = 0, tready = 1, drop_count = 0; a fresh read after release is processed correctly.
